mdu_seq: RTL and testbench

//  Multi-cycle sequencer for RV32M multiply/divide, next to the single-cycle EX-stage ALU.

---
 rtl/mdu_seq_pkg.sv | 48 ++++
 rtl/mdu_step.sv | 33 +++
 rtl/mdu_seq.sv | 146 ++++++++++++++
 tb/tb_mdu_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op codes follow the RV32M funct3 order so EX can forward funct3 directly.
package mdu_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Per-op context latched at accept and consumed by the final correction.
  typedef struct packed {
    md_op_e op;
    logic   sign1;
    logic   sign2;
    logic   special;
  } mdu_ctx_t;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op1_signed(input md_op_e op);
    return !(op inside {MD_MULHU, MD_DIVU, MD_REMU});
  endfunction

  function automatic logic op2_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide on operand magnitudes.
// Multiply: {acc,sreg} is the product shifting right. Divide: acc is the remainder, sreg dividend->quotient.
module mdu_step
  import mdu_seq_pkg::*;
(
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] sreg,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] sreg_nxt
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] rem_diff;

  always_comb begin
    mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
    rem_shift = {acc, sreg[XLEN-1]};
    // The remainder stays below the divisor, so bit XLEN of the difference is the borrow.
    rem_diff  = rem_shift - {1'b0, opnd};

    acc_nxt  = mul_sum[XLEN:1];
    sreg_nxt = {mul_sum[0], sreg[XLEN-1:1]};

    if (div_mode) begin
      acc_nxt  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
      sreg_nxt = {sreg[XLEN-2:0], ~rem_diff[XLEN]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// Iterates 32 magnitude steps, then applies sign correction and result selection.
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      MdOp,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MdOut
);

  mdu_state_e      state;
  logic [CNT_W-1:0] cnt;
  mdu_ctx_t        ctx;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] sreg;
  logic [XLEN-1:0] opnd;

  md_op_e          op_c;
  logic            s1_c;
  logic            s2_c;
  logic [XLEN-1:0] mag1_c;
  logic [XLEN-1:0] mag2_c;
  logic            div_zero_c;
  logic            div_ovf_c;
  logic            special_c;
  logic [XLEN-1:0] spec_res_c;

  logic [XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]   sreg_nxt;
  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c;
  logic [XLEN-1:0]   rem_c;
  logic [XLEN-1:0]   fix_res_c;

  // Issue-side decode: operand magnitudes and the cases resolved without iterating.
  always_comb begin
    op_c       = md_op_e'(MdOp);
    s1_c       = op1_signed(op_c) & Operand1[XLEN-1];
    s2_c       = op2_signed(op_c) & Operand2[XLEN-1];
    mag1_c     = s1_c ? -Operand1 : Operand1;
    mag2_c     = s2_c ? -Operand2 : Operand2;
    div_zero_c = is_div(op_c) && (Operand2 == '0);
    div_ovf_c  = (op_c == MD_DIV || op_c == MD_REM) &&
                 (Operand1 == INT_MIN) && (Operand2 == '1);
    special_c  = div_zero_c || div_ovf_c;
    spec_res_c = op_c[1] ? '0 : INT_MIN;
    if (div_zero_c) begin
      spec_res_c = op_c[1] ? Operand1 : '1;
    end
  end

  mdu_step u_step (
    .div_mode (is_div(ctx.op)),
    .acc      (acc),
    .sreg     (sreg),
    .opnd     (opnd),
    .acc_nxt  (acc_nxt),
    .sreg_nxt (sreg_nxt)
  );

  // Sign correction and hi/lo or quotient/remainder selection.
  always_comb begin
    prod_mag  = {acc, sreg};
    prod_c    = (ctx.sign1 ^ ctx.sign2) ? -prod_mag : prod_mag;
    quo_c     = (ctx.sign1 ^ ctx.sign2) ? -sreg : sreg;
    rem_c     = ctx.sign1 ? -acc : acc;
    fix_res_c = (ctx.op == MD_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    if (ctx.special) begin
      fix_res_c = sreg;
    end else if (is_div(ctx.op)) begin
      fix_res_c = ctx.op[1] ? rem_c : quo_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      ctx   <= '0;
      acc   <= '0;
      sreg  <= '0;
      opnd  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      MdOut <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start && !flush) begin
            ctx  <= '{op: op_c, sign1: s1_c, sign2: s2_c, special: special_c};
            cnt  <= '0;
            busy <= 1'b1;
            acc  <= '0;
            opnd <= mag2_c;
            // Special cases skip CALC; passing through FIX puts done two cycles after accept.
            if (special_c) begin
              sreg  <= spec_res_c;
              state <= MDU_FIX;
            end else begin
              sreg  <= mag1_c;
              state <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end else begin
            acc  <= acc_nxt;
            sreg <= sreg_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              state <= MDU_FIX;
            end
          end
        end
        MDU_FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end else begin
            MdOut <= fix_res_c;
            done  <= 1'b1;
            state <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          busy  <= 1'b0;
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes expected results with their due cycle,
// a monitor pops and compares on every done, and also tracks busy and MdOut hold.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  MdOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic        busy;
  logic        done;
  logic [31:0] MdOut;

  mdu_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .MdOp     (MdOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .MdOut    (MdOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        scb[$];
  int          checks    = 0;
  int          failures  = 0;
  int          busy_lo   = 1;
  int          busy_hi   = 0;
  bit          finishing = 1'b0;
  logic [31:0] exp_mdout = '0;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      MD_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb);
        return p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub);
        return p[31:0];
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if ((op == MD_DIV || op == MD_DIVU || op == MD_REM || op == MD_REMU) && b == 0) return 1'b1;
    return (op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares busy, done/result timing and MdOut hold once per cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) exp_mdout = '0;
    chk("busy", 32'(busy), 32'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
    if (done === 1'b1) begin
      if (scb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = scb.pop_front();
        chk("result", MdOut, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.due));
        exp_mdout = e.res;
      end
    end else begin
      chk("mdout_hold", MdOut, exp_mdout);
      if (scb.size() != 0 && cyc >= scb[0].due) begin
        chk("done_timeout", 32'(done), 32'd1);
        void'(scb.pop_front());
      end
    end
    if (finishing) begin
      chk("scoreboard_empty", 32'(scb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
    end
  endtask

  // Issues one op; optional flush at offset flush_k, random start pulses while busy,
  // and a start+flush attempt first. Always pulses start in the DONE cycle; returns there.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_k, input bit glitch, input bit pre_flush);
    int lat;
    int c;
    lat = is_special(op, a, b) ? 2 : 34;
    @(negedge clk);
    start = 1'b1; flush = pre_flush; MdOp = op; Operand1 = a; Operand2 = b;
    if (pre_flush) begin
      @(negedge clk);
      flush = 1'b0;
    end
    c = cyc;
    scb.push_back('{res: ref_model(op, a, b), due: c + lat});
    busy_lo = c + 1;
    busy_hi = c + lat;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = (k == lat) || (glitch && $urandom_range(0, 1) == 1);
      if (start) begin
        MdOp = 3'($urandom_range(0, 7)); Operand1 = $urandom; Operand2 = $urandom;
      end
      flush = (k == flush_k);
      if (flush && k < lat) begin
        void'(scb.pop_back());
        busy_hi = cyc;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        return;
      end
    end
  endtask

  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b);
    int c;
    @(negedge clk);
    flush = 1'b0; start = 1'b1; MdOp = MD_MUL; Operand1 = a; Operand2 = b;
    c = cyc;
    scb.push_back('{res: ref_model(MD_MUL, a, b), due: c + 34});
    busy_lo = c + 1;
    busy_hi = c + 34;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    void'(scb.pop_back());
    busy_hi = cyc;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    MdOp = '0; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 0, 0, 0); idle(1);
    run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 0, 0, 0); idle(1);
    run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, 0); idle(2);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         0, 0, 0); idle(1);
    run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         0, 0, 0); idle(1);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         0, 0, 0); idle(1);
    run_op(MD_DIVU,   32'd100,        32'd7,         0, 0, 0); idle(1);
    run_op(MD_REMU,   32'd100,        32'd7,         0, 0, 0); idle(1);
    run_op(MD_DIVU,   32'd5,          32'd0,         0, 0, 0); idle(1);
    run_op(MD_REM,    32'd7,          32'd0,         0, 0, 0); idle(1);
    run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0, 0, 0); idle(1);
    run_op(MD_DIV,    32'd1000,       32'd7,        10, 0, 0); idle(2);
    run_op(MD_MUL,    32'd3,          32'd4,         0, 0, 0);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         0, 1, 0);
    run_op(MD_MULHU,  32'h1234_5678,  32'h9ABC_DEF0, 0, 1, 1); idle(1);
    run_op(MD_DIVU,   32'd9,          32'd0,         1, 0, 0); idle(1);
    run_op(MD_REMU,   32'd9,          32'd0,         2, 0, 0); idle(1);
    run_op(MD_DIV,    32'hDEAD_BEEF,  32'd3,        34, 0, 0); idle(1);
    reset_mid(32'h1234, 32'h5678);
    run_op(MD_MUL,    32'd6,          32'd7,         0, 0, 0); idle(1);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      idle($urandom_range(0, 2));
    end

    idle(3);
    finishing = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
